fclk_div_buf: RTL and testbench
===============================

# fclk_div_buf

Multi-channel programmable fabric clock divider with glitch-free enable and ratio change. Each channel divides the input clock by an even ratio, holds a 50% duty cycle, and drives a registered clock output for routing onto the global clock network. Ratio updates use a four-phase handshake and take effect only at a low-phase boundary, so the output never produces a runt pulse. It extends the plain pass-through clock buffer with per-channel division, gating and reconfiguration.

## Interface
- NUM_CH, 2, number of independent divider channels (1..8)
- DIV_W, 8, width of each channel's ratio field
- C  input  1  clock input; all logic on rising edge
- R  input  1  asynchronous active-low reset
- EN  input  NUM_CH  per-channel run enable
- DIV  input  NUM_CH*DIV_W  per-channel ratio code d; channel k uses bits [k*DIV_W +: DIV_W]
- LOAD  input  NUM_CH  per-channel ratio-load request (level, four-phase)
- ACK  output  NUM_CH  per-channel ratio-load acknowledge (level, four-phase)
- O  output  NUM_CH  per-channel divided clock output, registered
- LOCK  output  NUM_CH  per-channel stable indication (only with FCLK_DIV_LOCK_EN)

## Operation
- Per-channel active ratio register `ratio` (DIV_W bits) and phase counter `cnt` (DIV_W bits).
- Output period = 2*(ratio+1) C cycles; high for ratio+1 cycles, then low for ratio+1 cycles. d=0 gives divide-by-2; d=2^DIV_W-1 is the maximum; no overflow (cnt compares against ratio, wraps to 0).
- States: IDLE (O=0, cnt=0), HIGH, LOW.
  - IDLE -> HIGH when EN=1; cnt=0.
  - HIGH: cnt++ each cycle; at cnt==ratio go to LOW, cnt=0.
  - LOW: cnt++; at cnt==ratio go to HIGH if EN=1, else IDLE; cnt=0.
  - EN dropping during HIGH or LOW does not cut the phase short; the channel finishes the current LOW phase (completing HIGH first if needed), then goes to IDLE. No shortened high or low pulse is ever emitted.
- Load handshake (four-phase): the requester raises LOAD with DIV stable and holds both until ACK=1, then drops LOAD; ACK falls the cycle after LOAD is seen low. A new request requires LOAD low while ACK=0.
  - Capture point: in IDLE, capture on the first cycle LOAD=1. In HIGH or LOW, capture at the LOW->HIGH (or LOW->IDLE) boundary cycle.
  - On capture, ratio<=DIV[k] and ACK rises in the same edge. The new ratio governs the next phase.
  - DIV changes while LOAD=1 and ACK=0 are a protocol violation; behaviour is undefined but glitch-free (any captured value is legal).
- Channels are fully independent; no cross-channel phase alignment.

## Timing
- Reset (R=0, async): O=0, ACK=0, LOCK=0, ratio=0, cnt=0, state IDLE, regardless of C. A mid-period reset forces O low immediately; a short high pulse is accepted here.
- Release of R is synchronous in effect; the first EN sampling is on the first rising C with R=1.
- EN rise sampled at edge t: O=1 after edge t+1 (one-cycle latency).
- O toggles only on rising C; no combinational path from any input to O.
- ACK latency: IDLE is 1 cycle after LOAD is seen. Running is up to 2*(ratio+1) cycles.
- Simultaneous EN fall and LOAD in LOW at the boundary: capture occurs, the channel enters IDLE, and the next start uses the new ratio.

## Configuration
- FCLK_DIV_LOCK_EN defined: the LOCK port exists. LOCK[k] rises at the first LOW->HIGH transition after a full HIGH+LOW period at an unchanged ratio. It falls on capture, on entry to IDLE, and on reset.
- Undefined: the LOCK port and its logic are absent; all other behaviour is identical.

## Structure
- Package fclk_div_pkg: state enum (IDLE, HIGH, LOW) and the default DIV_W constant.
- Sub-module fclk_div_ch: one channel, holding its state machine, counter, ratio register, handshake and optional LOCK. The top instantiates NUM_CH copies via generate.

## Test plan
- Reset, then EN[0]=1 with ratio 0: O[0] toggles every cycle (period 2) starting one cycle after EN is sampled. ACK=0 and O[1]=0 throughout.
- IDLE load of d=3, then EN=1: ACK is high 1 cycle after LOAD; O is high 4 cycles and low 4 cycles repeatedly.
- Running at d=3, LOAD d=1 mid-HIGH: the current 4-high/4-low period completes, ACK rises at the boundary, then the output runs 2-high/2-low. No pulse is shorter than 2 cycles.
- Running at d=2, EN dropped on the 1st HIGH cycle: 3 high then 3 low cycles complete, then O=0 steady. Re-enabling gives a full 3-cycle high.
- R asserted mid-HIGH at d=5: O goes to 0 without waiting for C. After release, the ratio has reverted to 0 (period 2 on next enable).
- FCLK_DIV_LOCK_EN, d=1: LOCK rises after the first full 4-cycle period and drops the cycle a new ratio is captured.

Source files
------------

// File: rtl/fclk_div_pkg.sv
// Shared types and constants for the fclk_div_buf clock divider.
// Optional LOCK output is enabled with FCLK_DIV_LOCK_EN.
package fclk_div_pkg;

    localparam int DIV_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } ch_state_t;

endpackage

// File: rtl/fclk_div_ch.sv
// One divider channel: phase state machine, counter, ratio register, load handshake.
// Optional LOCK output is enabled with FCLK_DIV_LOCK_EN.
module fclk_div_ch
    import fclk_div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_load,
    output logic             o_ack,
`ifdef FCLK_DIV_LOCK_EN
    output logic             o_lock,
`endif
    output logic             o_clk
);

    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    ch_state_t        r_state;
    ch_state_t        w_stateNext;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cntNext;
    logic [DIV_W-1:0] r_ratio;
    logic             r_ack;
    logic             r_o;
    logic             w_phaseEnd;
    logic             w_capture;

    assign w_phaseEnd = (r_cnt == r_ratio);

    // A new ratio is only taken while idle or on the last LOW cycle, so a phase is never cut short.
    assign w_capture  = i_load && !r_ack &&
                        ((r_state == IDLE) || ((r_state == LOW) && w_phaseEnd));

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        case (r_state)
            IDLE: begin
                w_cntNext = '0;
                if (i_en) begin
                    w_stateNext = HIGH;
                end
            end
            HIGH: begin
                if (w_phaseEnd) begin
                    w_stateNext = LOW;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + CNT_ONE;
                end
            end
            LOW: begin
                if (w_phaseEnd) begin
                    w_stateNext = i_en ? HIGH : IDLE;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    // The output is registered from the current state, giving one cycle of latency after a start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_o     <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_o     <= (r_state == HIGH);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ratio <= '0;
            r_ack   <= 1'b0;
        end else if (w_capture) begin
            r_ratio <= i_div;
            r_ack   <= 1'b1;
        end else if (r_ack && !i_load) begin
            r_ack   <= 1'b0;
        end
    end

`ifdef FCLK_DIV_LOCK_EN
    logic r_lock;
    logic r_seenHigh;

    // Lock needs a complete HIGH then LOW at the current ratio; any capture or stop restarts that.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock     <= 1'b0;
            r_seenHigh <= 1'b0;
        end else if (w_capture || (w_stateNext == IDLE)) begin
            r_lock     <= 1'b0;
            r_seenHigh <= 1'b0;
        end else begin
            if ((r_state == HIGH) && w_phaseEnd) begin
                r_seenHigh <= 1'b1;
            end
            if ((r_state == LOW) && w_phaseEnd && r_seenHigh) begin
                r_lock <= 1'b1;
            end
        end
    end

    assign o_lock = r_lock;
`endif

    assign o_ack = r_ack;
    assign o_clk = r_o;

endmodule

// File: rtl/fclk_div_buf.sv
// Multi-channel even-ratio fabric clock divider with glitch-free enable and ratio reload.
// Optional per-channel LOCK port is enabled with FCLK_DIV_LOCK_EN.
module fclk_div_buf
    import fclk_div_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = DIV_W_DEFAULT
) (
    input  logic                    C,
    input  logic                    R,
    input  logic [NUM_CH-1:0]       EN,
    input  logic [NUM_CH*DIV_W-1:0] DIV,
    input  logic [NUM_CH-1:0]       LOAD,
    output logic [NUM_CH-1:0]       ACK,
`ifdef FCLK_DIV_LOCK_EN
    output logic [NUM_CH-1:0]       LOCK,
`endif
    output logic [NUM_CH-1:0]       O
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        fclk_div_ch #(
            .DIV_W (DIV_W)
        ) u_ch (
            .i_clk   (C),
            .i_rst_n (R),
            .i_en    (EN[k]),
            .i_div   (DIV[k*DIV_W +: DIV_W]),
            .i_load  (LOAD[k]),
            .o_ack   (ACK[k]),
`ifdef FCLK_DIV_LOCK_EN
            .o_lock  (LOCK[k]),
`endif
            .o_clk   (O[k])
        );
    end

endmodule

// File: tb/tb_fclk_div_buf.sv
// Scoreboard bench for fclk_div_buf (2 channels, 8-bit ratios).
// LOCK checks are compiled in when FCLK_DIV_LOCK_EN is defined.
module tb_fclk_div_buf;

    typedef struct packed {
        logic [1:0] o;
        logic [1:0] ack;
        logic [1:0] lock;
    } exp_t;

    logic        C;
    logic        R;
    logic [1:0]  EN;
    logic [15:0] DIV;
    logic [1:0]  LOAD;
    logic [1:0]  ACK;
    logic [1:0]  O;
`ifdef FCLK_DIV_LOCK_EN
    logic [1:0]  LOCK;
`endif

    exp_t expQ[$];
    int   assertCount = 0;
    int   failCount   = 0;

    fclk_div_buf #(
        .NUM_CH (2),
        .DIV_W  (8)
    ) dut (
        .C    (C),
        .R    (R),
        .EN   (EN),
        .DIV  (DIV),
        .LOAD (LOAD),
        .ACK  (ACK),
`ifdef FCLK_DIV_LOCK_EN
        .LOCK (LOCK),
`endif
        .O    (O)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic pushExp(input logic [1:0] o, input logic [1:0] ack, input logic [1:0] lock);
        exp_t e;
        e.o    = o;
        e.ack  = ack;
        e.lock = lock;
        expQ.push_back(e);
    endtask

    // Called just after a rising edge; leaves the DUT idle with ratio 0 between edges.
    task automatic doReset();
        R    = 1'b0;
        EN   = 2'b00;
        LOAD = 2'b00;
        DIV  = 16'd0;
        #3;
        R    = 1'b1;
    endtask

    task automatic test_reset();
        R = 1'b0; EN = 2'b00; LOAD = 2'b00; DIV = 16'd0;
        #2;
        assertCount++;
        if (O !== 2'b00) begin failCount++; $display("[TB] FAIL reset_async O: got %b expected 00", O); end
        assertCount++;
        if (ACK !== 2'b00) begin failCount++; $display("[TB] FAIL reset_async ACK: got %b expected 00", ACK); end
        @(posedge C); #1;
        assertCount++;
        if (O !== 2'b00) begin failCount++; $display("[TB] FAIL reset_held O: got %b expected 00", O); end
        #2;
        R = 1'b1;
        @(posedge C); #1;
        assertCount++;
        if (O !== 2'b00) begin failCount++; $display("[TB] FAIL reset_release O: got %b expected 00", O); end
        assertCount++;
        if (ACK !== 2'b00) begin failCount++; $display("[TB] FAIL reset_release ACK: got %b expected 00", ACK); end
    endtask

    task automatic test_div2();
        exp_t e;
        int   i;
        doReset();
        EN = 2'b01;
        pushExp(2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 8; k++) pushExp((k % 2 == 0) ? 2'b01 : 2'b00, 2'b00, 2'b00);
        i = 0;
        while (expQ.size() > 0) begin
            @(posedge C); #1; i++;
            e = expQ.pop_front();
            assertCount++;
            if (O !== e.o) begin failCount++; $display("[TB] FAIL div2 O cycle %0d: got %b expected %b", i, O, e.o); end
            assertCount++;
            if (ACK !== e.ack) begin failCount++; $display("[TB] FAIL div2 ACK cycle %0d: got %b expected %b", i, ACK, e.ack); end
        end
    endtask

    task automatic test_idle_load();
        exp_t e;
        int   i;
        doReset();
        DIV  = {8'd0, 8'd3};
        LOAD = 2'b01;
        pushExp(2'b00, 2'b01, 2'b00);
        pushExp(2'b00, 2'b00, 2'b00);
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 4; k++) pushExp((p % 2 == 0) ? 2'b01 : 2'b00, 2'b00, 2'b00);
        i = 0;
        while (expQ.size() > 0) begin
            @(posedge C); #1; i++;
            e = expQ.pop_front();
            assertCount++;
            if (O !== e.o) begin failCount++; $display("[TB] FAIL idle_load O cycle %0d: got %b expected %b", i, O, e.o); end
            assertCount++;
            if (ACK !== e.ack) begin failCount++; $display("[TB] FAIL idle_load ACK cycle %0d: got %b expected %b", i, ACK, e.ack); end
            if (i == 1) begin LOAD = 2'b00; EN = 2'b01; end
        end
    endtask

    task automatic test_ratio_change();
        exp_t e;
        int   i;
        doReset();
        DIV  = {8'd0, 8'd3};
        LOAD = 2'b01;
        pushExp(2'b00, 2'b01, 2'b00);
        pushExp(2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 4; k++) pushExp(2'b01, 2'b00, 2'b00);
        for (int k = 0; k < 3; k++) pushExp(2'b00, 2'b00, 2'b00);
        pushExp(2'b00, 2'b01, 2'b00);
        for (int k = 0; k < 10; k++) pushExp(((k / 2) % 2 == 0) ? 2'b01 : 2'b00, 2'b00, 2'b00);
        i = 0;
        while (expQ.size() > 0) begin
            @(posedge C); #1; i++;
            e = expQ.pop_front();
            assertCount++;
            if (O !== e.o) begin failCount++; $display("[TB] FAIL ratio_change O cycle %0d: got %b expected %b", i, O, e.o); end
            assertCount++;
            if (ACK !== e.ack) begin failCount++; $display("[TB] FAIL ratio_change ACK cycle %0d: got %b expected %b", i, ACK, e.ack); end
            if (i == 1)  begin LOAD = 2'b00; EN = 2'b01; end
            if (i == 4)  begin DIV = {8'd0, 8'd1}; LOAD = 2'b01; end
            if (i == 10) LOAD = 2'b00;
        end
    endtask

    task automatic test_en_drop();
        exp_t e;
        int   i;
        doReset();
        DIV  = {8'd0, 8'd2};
        LOAD = 2'b01;
        pushExp(2'b00, 2'b01, 2'b00);
        pushExp(2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 3; k++) pushExp(2'b01, 2'b00, 2'b00);
        for (int k = 0; k < 7; k++) pushExp(2'b00, 2'b00, 2'b00);
        pushExp(2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 3; k++) pushExp(2'b01, 2'b00, 2'b00);
        pushExp(2'b00, 2'b00, 2'b00);
        i = 0;
        while (expQ.size() > 0) begin
            @(posedge C); #1; i++;
            e = expQ.pop_front();
            assertCount++;
            if (O !== e.o) begin failCount++; $display("[TB] FAIL en_drop O cycle %0d: got %b expected %b", i, O, e.o); end
            assertCount++;
            if (ACK !== e.ack) begin failCount++; $display("[TB] FAIL en_drop ACK cycle %0d: got %b expected %b", i, ACK, e.ack); end
            if (i == 1)  begin LOAD = 2'b00; EN = 2'b01; end
            if (i == 2)  EN = 2'b00;
            if (i == 12) EN = 2'b01;
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   i;
        doReset();
        DIV  = {8'd0, 8'd5};
        LOAD = 2'b01;
        pushExp(2'b00, 2'b01, 2'b00);
        pushExp(2'b00, 2'b00, 2'b00);
        pushExp(2'b01, 2'b00, 2'b00);
        pushExp(2'b01, 2'b00, 2'b00);
        i = 0;
        while (expQ.size() > 0) begin
            @(posedge C); #1; i++;
            e = expQ.pop_front();
            assertCount++;
            if (O !== e.o) begin failCount++; $display("[TB] FAIL async_reset_pre O cycle %0d: got %b expected %b", i, O, e.o); end
            if (i == 1) begin LOAD = 2'b00; EN = 2'b01; end
        end
        #2;
        R = 1'b0;
        #1;
        assertCount++;
        if (O !== 2'b00) begin failCount++; $display("[TB] FAIL async_reset_mid O: got %b expected 00", O); end
        assertCount++;
        if (ACK !== 2'b00) begin failCount++; $display("[TB] FAIL async_reset_mid ACK: got %b expected 00", ACK); end
        EN = 2'b00;
        #1;
        R  = 1'b1;
        EN = 2'b01;
        pushExp(2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 4; k++) pushExp((k % 2 == 0) ? 2'b01 : 2'b00, 2'b00, 2'b00);
        i = 0;
        while (expQ.size() > 0) begin
            @(posedge C); #1; i++;
            e = expQ.pop_front();
            assertCount++;
            if (O !== e.o) begin failCount++; $display("[TB] FAIL async_reset_post O cycle %0d: got %b expected %b", i, O, e.o); end
        end
    endtask

    task automatic test_two_channels();
        exp_t e;
        int   i;
        logic o0;
        logic o1;
        doReset();
        DIV  = {8'd1, 8'd0};
        LOAD = 2'b10;
        pushExp(2'b00, 2'b10, 2'b00);
        pushExp(2'b00, 2'b00, 2'b00);
        for (int c = 3; c <= 10; c++) begin
            o0 = (c % 2 == 1);
            o1 = (((c - 3) % 4) < 2);
            pushExp({o1, o0}, 2'b00, 2'b00);
        end
        i = 0;
        while (expQ.size() > 0) begin
            @(posedge C); #1; i++;
            e = expQ.pop_front();
            assertCount++;
            if (O !== e.o) begin failCount++; $display("[TB] FAIL two_ch O cycle %0d: got %b expected %b", i, O, e.o); end
            assertCount++;
            if (ACK !== e.ack) begin failCount++; $display("[TB] FAIL two_ch ACK cycle %0d: got %b expected %b", i, ACK, e.ack); end
            if (i == 1) begin LOAD = 2'b00; EN = 2'b11; end
        end
    endtask

    task automatic test_max_ratio();
        exp_t e;
        int   i;
        doReset();
        DIV  = {8'd0, 8'd255};
        LOAD = 2'b01;
        pushExp(2'b00, 2'b01, 2'b00);
        pushExp(2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 256; k++) pushExp(2'b01, 2'b00, 2'b00);
        for (int k = 0; k < 256; k++) pushExp(2'b00, 2'b00, 2'b00);
        pushExp(2'b01, 2'b00, 2'b00);
        i = 0;
        while (expQ.size() > 0) begin
            @(posedge C); #1; i++;
            e = expQ.pop_front();
            assertCount++;
            if (O !== e.o) begin failCount++; $display("[TB] FAIL max_ratio O cycle %0d: got %b expected %b", i, O, e.o); end
            assertCount++;
            if (ACK !== e.ack) begin failCount++; $display("[TB] FAIL max_ratio ACK cycle %0d: got %b expected %b", i, ACK, e.ack); end
            if (i == 1) begin LOAD = 2'b00; EN = 2'b01; end
        end
    endtask

`ifdef FCLK_DIV_LOCK_EN
    task automatic test_lock();
        exp_t e;
        int   i;
        doReset();
        DIV  = {8'd0, 8'd1};
        LOAD = 2'b01;
        pushExp(2'b00, 2'b01, 2'b00);
        pushExp(2'b00, 2'b00, 2'b00);
        pushExp(2'b01, 2'b00, 2'b00);
        pushExp(2'b01, 2'b00, 2'b00);
        pushExp(2'b00, 2'b00, 2'b00);
        pushExp(2'b00, 2'b00, 2'b01);
        pushExp(2'b01, 2'b00, 2'b01);
        pushExp(2'b01, 2'b00, 2'b01);
        pushExp(2'b00, 2'b00, 2'b01);
        pushExp(2'b00, 2'b01, 2'b00);
        for (int k = 0; k < 4; k++) pushExp(2'b01, 2'b00, 2'b00);
        for (int k = 0; k < 3; k++) pushExp(2'b00, 2'b00, 2'b00);
        pushExp(2'b00, 2'b00, 2'b01);
        i = 0;
        while (expQ.size() > 0) begin
            @(posedge C); #1; i++;
            e = expQ.pop_front();
            assertCount++;
            if (O !== e.o) begin failCount++; $display("[TB] FAIL lock O cycle %0d: got %b expected %b", i, O, e.o); end
            assertCount++;
            if (ACK !== e.ack) begin failCount++; $display("[TB] FAIL lock ACK cycle %0d: got %b expected %b", i, ACK, e.ack); end
            assertCount++;
            if (LOCK !== e.lock) begin failCount++; $display("[TB] FAIL lock LOCK cycle %0d: got %b expected %b", i, LOCK, e.lock); end
            if (i == 1)  begin LOAD = 2'b00; EN = 2'b01; end
            if (i == 7)  begin DIV = {8'd0, 8'd3}; LOAD = 2'b01; end
            if (i == 10) LOAD = 2'b00;
        end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        R    = 1'b0;
        EN   = 2'b00;
        LOAD = 2'b00;
        DIV  = 16'd0;
        test_reset();
        test_div2();
        test_idle_load();
        test_ratio_change();
        test_en_drop();
        test_async_reset();
        test_two_channels();
        test_max_ratio();
`ifdef FCLK_DIV_LOCK_EN
        test_lock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
